// File: rtl/card_slot_buffer_pkg.sv
// Shared constants for the card slot buffer, the VGA controller and the software memory map.
package card_slot_buffer_pkg;

    localparam int SLOTS      = 6;
    localparam int BASE_ADDR  = 16;
    localparam int CTRL_ADDR  = BASE_ADDR + SLOTS;
    localparam int EMPTY_CARD = 0;
    localparam int MAX_CARD   = 52;
    localparam int CARD_W     = 6;
    localparam int COUNT_W    = 4;

    localparam int CLR_BIT    = 0;
    localparam int ERRCLR_BIT = 1;

    typedef logic [CARD_W-1:0] card_t;

endpackage

// File: rtl/card_slot_buffer_if.sv
// Processor store port, frame pulse and VGA read/status signals of the card slot buffer.
interface card_slot_buffer_if;
    import card_slot_buffer_pkg::*;

    logic               wEn;
    logic [31:0]        wAddr;
    logic [31:0]        wData;
    logic               screenEnd;
    logic [31:0]        RAMaddr;
    logic [31:0]        cardIndex;
    logic [COUNT_W-1:0] cardCount;
    logic               pending;
    logic               err;

    modport master (
        output wEn, wAddr, wData, screenEnd, RAMaddr,
        input  cardIndex, cardCount, pending, err
    );

    modport slave (
        input  wEn, wAddr, wData, screenEnd, RAMaddr,
        output cardIndex, cardCount, pending, err
    );

endinterface

// File: rtl/card_slot_buffer_slot_popcount.sv
// Combinational count of nonzero card slots; the parent registers the result.
module card_slot_buffer_slot_popcount
    import card_slot_buffer_pkg::*;
#(
    parameter int N_SLOTS = SLOTS,
    parameter int W       = CARD_W
) (
    input  logic [N_SLOTS-1:0][W-1:0] i_slots,
    output logic [COUNT_W-1:0]        o_count
);

    logic [N_SLOTS-1:0] w_nonzero;

    generate
        for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_nz
            assign w_nonzero[gi] = |i_slots[gi];
        end
    endgenerate

    always_comb begin
        logic [COUNT_W-1:0] w_acc;
        w_acc = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            w_acc = w_acc + COUNT_W'(w_nonzero[k]);
        end
        o_count = w_acc;
    end

endmodule

// File: rtl/card_slot_buffer.sv
// Double-banked card index store: processor writes staging, screenEnd copies staging into the
// display bank read combinationally by the VGA controller, so a hand never changes mid-frame.
module card_slot_buffer
    import card_slot_buffer_pkg::*;
(
    input logic               clk,
    input logic               reset,
    card_slot_buffer_if.slave bus
);

    card_t              r_staging [SLOTS];
    card_t              r_display [SLOTS];
    card_t              w_staging_next [SLOTS];
    logic [COUNT_W-1:0] r_card_count;
    logic               r_pending;
    logic               r_err;

    logic               w_slot_hit;
    logic               w_ctrl_hit;
    logic               w_card_ok;
    logic               w_rd_hit;
    logic               w_differ;
    logic [31:0]        w_wr_off;
    logic [31:0]        w_rd_off;
    card_t              w_rd_card;
    logic [COUNT_W-1:0] w_pop;
    logic [SLOTS-1:0][CARD_W-1:0] w_display_flat;

    // Full 32-bit range checks so addresses below BASE_ADDR cannot wrap into a slot.
    assign w_slot_hit = bus.wEn && (bus.wAddr >= 32'(BASE_ADDR))
                                && (bus.wAddr <  32'(BASE_ADDR + SLOTS));
    assign w_ctrl_hit = bus.wEn && (bus.wAddr == 32'(CTRL_ADDR));
    assign w_card_ok  = (bus.wData <= 32'(MAX_CARD));
    assign w_wr_off   = bus.wAddr - 32'(BASE_ADDR);

    assign w_rd_hit   = (bus.RAMaddr >= 32'(BASE_ADDR))
                     && (bus.RAMaddr <  32'(BASE_ADDR + SLOTS));
    assign w_rd_off   = bus.RAMaddr - 32'(BASE_ADDR);

    always_comb begin
        for (int k = 0; k < SLOTS; k++) begin
            w_staging_next[k] = r_staging[k];
            if (w_ctrl_hit && bus.wData[CLR_BIT]) begin
                w_staging_next[k] = card_t'(EMPTY_CARD);
            end else if (w_slot_hit && w_card_ok && (w_wr_off == 32'(k))) begin
                w_staging_next[k] = bus.wData[CARD_W-1:0];
            end
        end
    end

    // Compare against what display will hold after this edge; a commit takes pre-write staging.
    always_comb begin
        w_differ = 1'b0;
        for (int k = 0; k < SLOTS; k++) begin
            if (w_staging_next[k] != (bus.screenEnd ? r_staging[k] : r_display[k])) begin
                w_differ = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SLOTS; k++) begin
                r_staging[k] <= '0;
                r_display[k] <= '0;
            end
        end else begin
            for (int k = 0; k < SLOTS; k++) begin
                r_staging[k] <= w_staging_next[k];
                if (bus.screenEnd) begin
                    r_display[k] <= r_staging[k];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err        <= 1'b0;
            r_pending    <= 1'b0;
            r_card_count <= '0;
        end else begin
            if (w_slot_hit && !w_card_ok) begin
                r_err <= 1'b1;
            end else if (w_ctrl_hit && bus.wData[ERRCLR_BIT]) begin
                r_err <= 1'b0;
            end
            r_pending    <= w_differ;
            r_card_count <= w_pop;
        end
    end

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_flat
            assign w_display_flat[gi] = r_display[gi];
        end
    endgenerate

    card_slot_buffer_slot_popcount #(
        .N_SLOTS (SLOTS),
        .W       (CARD_W)
    ) u_popcount (
        .i_slots (w_display_flat),
        .o_count (w_pop)
    );

    always_comb begin
        w_rd_card = card_t'(EMPTY_CARD);
        for (int k = 0; k < SLOTS; k++) begin
            if (w_rd_hit && (w_rd_off == 32'(k))) begin
                w_rd_card = r_display[k];
            end
        end
    end

    assign bus.cardIndex = 32'(w_rd_card);
    assign bus.cardCount = r_card_count;
    assign bus.pending   = r_pending;
    assign bus.err       = r_err;

endmodule
